// File: rtl/fft_loader_if.sv
// Point stream from the frame loader into the R2 pipeline FFT.
// en_fft qualifies cnt_fft/dout_*/frame_done; there is no ready, the consumer must take one point per clock.
interface fft_loader_if #(
    parameter int width = 16,
    parameter int N     = 9
);
    logic                    en_fft;
    logic [N-1:0]            cnt_fft;
    logic signed [width-1:0] dout_re;
    logic signed [width-1:0] dout_im;
    logic                    frame_done;

    modport master (output en_fft, cnt_fft, dout_re, dout_im, frame_done);
    modport slave  (input  en_fft, cnt_fft, dout_re, dout_im, frame_done);
endinterface

// File: rtl/fft_loader.sv
// Captures 2^N ADC samples at a divided rate into a RAM, then bursts them to the FFT.
// Optional macro ADC_OFFSET_BIN_EN: treat din_adc as offset-binary and flip its MSB on capture.
module fft_loader #(
    parameter int          width = 16,
    parameter int          N     = 9,
    parameter logic [23:0] fdiv  = 24'd1000
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             run,
    input  logic             hold,
    input  logic [width-1:0] din_adc,
    output logic             overrun,
    output logic [1:0]       dbg_state_o,
    fft_loader_if.master     fft
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_WAIT    = 2'd2,
        S_STREAM  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [23:0]      freq_cnt_q, freq_cnt_d;
    logic [N:0]       wr_cnt_q, wr_cnt_d;
    logic [N:0]       rd_cnt_q, rd_cnt_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             dropped;
    logic             we;
    logic             re;
    logic [N-1:0]     addr;
    logic [width-1:0] wdata;
    logic [width-1:0] mem [2**N];
    logic [width-1:0] rdata_q;
    logic             en_q;
    logic [N-1:0]     cnt_q;
    logic             done_q;

    assign tick = run && (freq_cnt_q == fdiv);

    always_comb begin
        freq_cnt_d = freq_cnt_q + 24'd1;
        if (!run || tick) begin
            freq_cnt_d = '0;
        end
    end

`ifdef ADC_OFFSET_BIN_EN
    assign wdata = {~din_adc[width-1], din_adc[width-2:0]};
`else
    assign wdata = din_adc;
`endif

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        we       = 1'b0;
        re       = 1'b0;
        addr     = wr_cnt_q[N-1:0];
        dropped  = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_cnt_d = '0;
                rd_cnt_d = '0;
                if (run) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!run) begin
                    state_d  = S_IDLE;
                    wr_cnt_d = '0;
                end else if (tick) begin
                    we       = 1'b1;
                    wr_cnt_d = wr_cnt_q + (N+1)'(1);
                    if (wr_cnt_q[N-1:0] == '1) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dropped = tick;
                if (!run) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                // Burst is atomic: run and hold are only looked at once the last address is out.
                dropped  = tick;
                re       = 1'b1;
                addr     = rd_cnt_q[N-1:0];
                rd_cnt_d = rd_cnt_q + (N+1)'(1);
                if (rd_cnt_q[N-1:0] == '1) begin
                    state_d  = run ? S_CAPTURE : S_IDLE;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        overrun_d = run && (overrun_q || dropped);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_IDLE;
            freq_cnt_q <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            freq_cnt_q <= freq_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Stream flags are delayed one clock so they line up with the RAM read data.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rdata_q <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            if (re) begin
                rdata_q <= mem[addr];
            end
            en_q   <= re;
            cnt_q  <= re ? addr : '0;
            done_q <= re && (addr == '1);
        end
    end

    assign fft.en_fft     = en_q;
    assign fft.cnt_fft    = cnt_q;
    assign fft.dout_re    = signed'(rdata_q);
    assign fft.dout_im    = '0;
    assign fft.frame_done = done_q;
    assign overrun        = overrun_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_fft_loader.sv
// Directed bench for fft_loader (fdiv=3): frame contents, burst timing, hold, overrun, abort, ADC coding.
module tb_fft_loader;
    localparam int W  = 16;
    localparam int NN = 9;
    localparam int FR = 512;

    logic         clk = 1'b0;
    logic         areset;
    logic         run;
    logic         hold;
    logic [W-1:0] din_adc;
    logic         overrun;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    fft_loader_if #(.width(W), .N(NN)) fif ();

    fft_loader #(.width(W), .N(NN), .fdiv(24'd3)) dut (
        .clk         (clk),
        .areset      (areset),
        .run         (run),
        .hold        (hold),
        .din_adc     (din_adc),
        .overrun     (overrun),
        .dbg_state_o (dbg_state),
        .fft         (fif)
    );

    int           checks = 0;
    int           failures = 0;
    int           ecount = 0;
    int           mode = 0;
    logic [W-1:0] pat [3] = '{16'h8000, 16'hFFFF, 16'h0000};
    logic [W-1:0] cap [3];

    // Model: sample m is the value on din_adc at the m-th tick after run rose.
    function automatic logic [W-1:0] din_of(input int m);
        if (mode == 1) return pat[m % 3];
        return m[W-1:0];
    endfunction

    function automatic logic [W-1:0] conv(input logic [W-1:0] d);
`ifdef ADC_OFFSET_BIN_EN
        return {~d[W-1], d[W-2:0]};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ecount = number of edges that have seen run high, i.e. the index of the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (run) ecount++;
        else ecount = 0;
        din_adc = din_of(ecount / 4);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_en(input int budget, input string name);
        for (int i = 0; i < budget && fif.en_fft !== 1'b1; i++) step();
        chk(name, fif.en_fft, 1'b1);
    endtask

    task automatic wait_end(input int budget, input string name);
        for (int i = 0; i < budget && fif.en_fft !== 1'b0; i++) step();
        chk(name, fif.en_fft, 1'b0);
    endtask

    // Scoreboard: every en cycle carries the next point of a frame of consecutive samples.
    int exp_idx = 0;
    int cur_start = 0;
    int next_start = 0;
    logic en_prev = 1'b0;

    always @(negedge clk) begin
        if (areset === 1'b1) begin
            chk("dout_im", {16'h0, fif.dout_im}, 32'h0);
            if (fif.en_fft === 1'b1) begin
                if (exp_idx == 0) cur_start = next_start;
                chk("cnt_fft", fif.cnt_fft, exp_idx);
                chk("dout_re", {16'h0, fif.dout_re}, conv(din_of(cur_start + exp_idx)));
                chk("frame_done", fif.frame_done, exp_idx == FR - 1);
                if (fif.cnt_fft < 3) cap[fif.cnt_fft] = fif.dout_re;
                if (exp_idx == FR - 1) begin
                    // Capture resumes with the first tick after the burst's last point.
                    next_start = ecount / 4;
                    exp_idx = 0;
                end else begin
                    exp_idx++;
                end
            end else begin
                if (fif.frame_done !== 1'b0) chk("frame_done_idle", fif.frame_done, 1'b0);
                if (en_prev) chk("burst_len", exp_idx, 0);
                exp_idx = 0;
            end
            if (!run) next_start = 0;
        end else begin
            exp_idx = 0;
        end
        en_prev = fif.en_fft;
    end

    initial begin
        int bad;
        areset  = 1'b0;
        run     = 1'b0;
        hold    = 1'b0;
        din_adc = '0;
        steps(4);
        chk("rst_en", fif.en_fft, 1'b0);
        chk("rst_cnt", fif.cnt_fft, 0);
        chk("rst_dout_re", {16'h0, fif.dout_re}, 0);
        chk("rst_dout_im", {16'h0, fif.dout_im}, 0);
        chk("rst_frame_done", fif.frame_done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        areset = 1'b1;

        bad = 0;
        repeat (10000) begin
            step();
            if (fif.en_fft !== 1'b0 || fif.frame_done !== 1'b0 || overrun !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Basic frame: 512 ticks 4 clocks apart, en one clock after WAIT.
        mode = 0;
        run  = 1'b1;
        wait_en(3000, "basic_en");
        chk("basic_latency", ecount, 2050);
        chk("basic_no_overrun", overrun, 1'b0);
        steps(100);
        hold = 1'b1;
        wait_end(600, "basic_end");
        chk("stream_overrun", overrun, 1'b1);

        // Hold deferral on the next frame.
        bad = 0;
        repeat (2048 + 200) begin
            step();
            if (fif.en_fft !== 1'b0) bad++;
        end
        chk("hold_defers", bad, 0);
        hold = 1'b0;
        step();
        chk("hold_rel_1clk", fif.en_fft, 1'b0);
        step();
        chk("hold_rel_2clk", fif.en_fft, 1'b1);
        steps(50);
        hold = 1'b1;
        run  = 1'b0;
        wait_end(600, "hold_burst_end");
        hold = 1'b0;
        steps(4);
        chk("overrun_cleared", overrun, 1'b0);

        // Overrun from 40 clocks of hold after fill, then two frames back to back.
        run  = 1'b1;
        hold = 1'b1;
        bad  = 0;
        repeat (2048 + 40) begin
            step();
            if (fif.en_fft !== 1'b0) bad++;
        end
        chk("ovr_no_en", bad, 0);
        chk("ovr_set", overrun, 1'b1);
        hold = 1'b0;
        wait_en(10, "ovr_en");
        wait_end(600, "ovr_end1");
        wait_en(3000, "ovr_en2");
        steps(10);
        run = 1'b0;
        wait_end(600, "ovr_end2");
        steps(4);

        // Abort after 100 samples; the next frame restarts from sample 0.
        run = 1'b1;
        bad = 0;
        repeat (100 * 4 + 2) begin
            step();
            if (fif.en_fft !== 1'b0) bad++;
        end
        run = 1'b0;
        repeat (5) begin
            step();
            if (fif.en_fft !== 1'b0) bad++;
        end
        chk("abort_no_en", bad, 0);
        run = 1'b1;
        wait_en(3000, "restart_en");
        chk("restart_latency", ecount, 2050);
        run = 1'b0;
        wait_end(600, "restart_end");
        steps(4);

        // ADC coding on 8000/FFFF/0000.
        mode = 1;
        run  = 1'b1;
        wait_en(3000, "pat_en");
        run  = 1'b0;
        wait_end(600, "pat_end");
`ifdef ADC_OFFSET_BIN_EN
        chk("pat_8000", {16'h0, cap[0]}, 32'h0000);
        chk("pat_FFFF", {16'h0, cap[1]}, 32'h7FFF);
        chk("pat_0000", {16'h0, cap[2]}, 32'h8000);
`else
        chk("pat_8000", {16'h0, cap[0]}, 32'h8000);
        chk("pat_FFFF", {16'h0, cap[1]}, 32'hFFFF);
        chk("pat_0000", {16'h0, cap[2]}, 32'h0000);
`endif
        steps(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
